// File: rtl/uart_cfg_if.sv
// Host-side bus of the configurable UART: framing config, TX/RX FIFO
// handshakes, serial pins and sticky error flags. slave = UART, master = host.
interface uart_cfg_if #(
  parameter int DBIT = 8
);
  logic [10:0]     dvsr_i;
  logic            par_en_i;
  logic            par_odd_i;
  logic            stop2_i;
  logic            wr_uart_i;
  logic [DBIT-1:0] w_data_i;
  logic            tx_full_o;
  logic            tx_idle_o;
  logic            tx_o;
  logic            rx_i;
  logic            rd_uart_i;
  logic [DBIT-1:0] r_data_o;
  logic            rx_empty_o;
  logic            par_err_o;
  logic            frm_err_o;
  logic            ovr_err_o;
  logic            clr_err_i;

  modport slave (
    input  dvsr_i, par_en_i, par_odd_i, stop2_i,
    input  wr_uart_i, w_data_i, rx_i,
    input  rd_uart_i, clr_err_i,
    output tx_full_o, tx_idle_o, tx_o,
    output r_data_o, rx_empty_o,
    output par_err_o, frm_err_o, ovr_err_o
  );

  modport master (
    output dvsr_i, par_en_i, par_odd_i, stop2_i,
    output wr_uart_i, w_data_i, rx_i,
    output rd_uart_i, clr_err_i,
    input  tx_full_o, tx_idle_o, tx_o,
    input  r_data_o, rx_empty_o,
    input  par_err_o, frm_err_o, ovr_err_o
  );
endinterface

// File: rtl/uart_cfg.sv
// Full-duplex UART, runtime framing (parity none/even/odd, 1/2 stop bits).
// Ports: clk_i, rst_i (async, active-high), bus (uart_cfg_if.slave).

// First-word-fall-through FIFO with registered full/empty flags.
module uart_cfg_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_i,
  input  logic          rd_i,
  input  logic [DW-1:0] w_data_i,
  output logic [DW-1:0] r_data_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [AW-1:0] wp_q, wp_d, wp_inc;
  logic [AW-1:0] rp_q, rp_d, rp_inc;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          we, re;

  assign re = rd_i & ~empty_q;
  // a write into a full FIFO is accepted only if a pop frees a slot
  assign we = wr_i & (~full_q | re);
  assign wp_inc = wp_q + 1'b1;
  assign rp_inc = rp_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (we) mem_q[wp_q] <= w_data_i;
  end

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    full_d  = full_q;
    empty_d = empty_q;
    case ({we, re})
      2'b10: begin
        wp_d    = wp_inc;
        empty_d = 1'b0;
        full_d  = (wp_inc == rp_q);
      end
      2'b01: begin
        rp_d    = rp_inc;
        full_d  = 1'b0;
        empty_d = (rp_inc == wp_q);
      end
      2'b11: begin
        wp_d = wp_inc;
        rp_d = rp_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign r_data_o = mem_q[rp_q];
  assign full_o   = full_q;
  assign empty_o  = empty_q;
endmodule

module uart_cfg #(
  parameter int DBIT   = 8,
  parameter int FIFO_W = 2,
  parameter int OSR    = 16
) (
  input logic     clk_i,
  input logic     rst_i,
  uart_cfg_if.slave bus
);
  localparam int SW = $clog2(OSR);
  localparam logic [SW-1:0] CNT_LAST = SW'(OSR - 1);
  localparam logic [SW-1:0] CNT_MID  = SW'(OSR / 2 - 1);
  localparam logic [3:0]    N_LAST   = 4'(DBIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP
  } st_t;

  // ---------------- baud tick ----------------
  logic [10:0] cnt_q, cnt_d;
  logic        tick;

  assign tick  = (cnt_q >= bus.dvsr_i);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // ---------------- FIFOs ----------------
  logic            tx_pop, tx_empty, tx_full;
  logic [DBIT-1:0] tx_head;
  logic            rx_push, rx_empty, rx_full;

  uart_cfg_fifo #(.DW(DBIT), .AW(FIFO_W)) u_txf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_i     (bus.wr_uart_i),
    .rd_i     (tx_pop),
    .w_data_i (bus.w_data_i),
    .r_data_o (tx_head),
    .full_o   (tx_full),
    .empty_o  (tx_empty)
  );

  logic [DBIT-1:0] rx_sh_q, rx_sh_d;

  uart_cfg_fifo #(.DW(DBIT), .AW(FIFO_W)) u_rxf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_i     (rx_push),
    .rd_i     (bus.rd_uart_i),
    .w_data_i (rx_sh_q),
    .r_data_o (bus.r_data_o),
    .full_o   (rx_full),
    .empty_o  (rx_empty)
  );

  // ---------------- TX FSM ----------------
  st_t             tx_st_q, tx_st_d;
  logic [SW-1:0]   tx_s_q, tx_s_d;
  logic [3:0]      tx_n_q, tx_n_d;
  logic [DBIT-1:0] tx_sh_q, tx_sh_d;
  logic            tx_par_q, tx_par_d;
  logic            tx_pen_q, tx_pen_d;
  logic            tx_stp2_q, tx_stp2_d;
  logic            tx_q, tx_bit, tx_last;

  assign tx_last = tick & (tx_s_q == CNT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_st_q   <= ST_IDLE;
      tx_s_q    <= '0;
      tx_n_q    <= '0;
      tx_sh_q   <= '0;
      tx_par_q  <= 1'b0;
      tx_pen_q  <= 1'b0;
      tx_stp2_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_s_q    <= tx_s_d;
      tx_n_q    <= tx_n_d;
      tx_sh_q   <= tx_sh_d;
      tx_par_q  <= tx_par_d;
      tx_pen_q  <= tx_pen_d;
      tx_stp2_q <= tx_stp2_d;
      tx_q      <= tx_bit;
    end
  end

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_s_d    = tx_s_q;
    tx_n_d    = tx_n_q;
    tx_sh_d   = tx_sh_q;
    tx_par_d  = tx_par_q;
    tx_pen_d  = tx_pen_q;
    tx_stp2_d = tx_stp2_q;
    if (tick && tx_st_q != ST_IDLE)
      tx_s_d = tx_last ? '0 : tx_s_q + 1'b1;
    unique case (tx_st_q)
      ST_START: begin
        if (tx_last) begin
          tx_n_d  = '0;
          tx_st_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_last) begin
          tx_sh_d = tx_sh_q >> 1;
          if (tx_n_q == N_LAST) begin
            tx_n_d  = '0;
            tx_st_d = tx_pen_q ? ST_PAR : ST_STOP;
          end else begin
            tx_n_d = tx_n_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (tx_last) tx_st_d = ST_STOP;
      end
      ST_STOP: begin
        if (tx_last) begin
          if (tx_stp2_q && !tx_n_q[0]) tx_n_d = 4'd1;
          else                         tx_st_d = ST_IDLE;
        end
      end
      default: ;
    endcase
    // loading a word overrides the above so frames chain with no gap
    if (tx_pop) begin
      tx_st_d   = ST_START;
      tx_s_d    = '0;
      tx_sh_d   = tx_head;
      tx_par_d  = ^tx_head ^ bus.par_odd_i;
      tx_pen_d  = bus.par_en_i;
      tx_stp2_d = bus.stop2_i;
    end
  end

  always_comb begin
    tx_bit = 1'b1;
    tx_pop = 1'b0;
    unique case (tx_st_q)
      ST_IDLE:  tx_pop = ~tx_empty;
      ST_START: tx_bit = 1'b0;
      ST_DATA:  tx_bit = tx_sh_q[0];
      ST_PAR:   tx_bit = tx_par_q;
      ST_STOP:  tx_pop = tx_last & ~tx_empty &
                         (~tx_stp2_q | tx_n_q[0]);
      default: ;
    endcase
  end

  // ---------------- RX FSM ----------------
  st_t           rx_st_q, rx_st_d;
  logic [SW-1:0] rx_s_q, rx_s_d;
  logic [3:0]    rx_n_q, rx_n_d;
  logic          rx_pen_q, rx_pen_d;
  logic          rx_podd_q, rx_podd_d;
  logic          rx_stp2_q, rx_stp2_d;
  logic [1:0]    sync_q;
  logic          rxs, rx_last;
  logic          par_set, frm_set, ovr_set;

  assign rxs     = sync_q[1];
  assign rx_last = tick & (rx_s_q == CNT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= 2'b11;
      rx_st_q   <= ST_IDLE;
      rx_s_q    <= '0;
      rx_n_q    <= '0;
      rx_sh_q   <= '0;
      rx_pen_q  <= 1'b0;
      rx_podd_q <= 1'b0;
      rx_stp2_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], bus.rx_i};
      rx_st_q   <= rx_st_d;
      rx_s_q    <= rx_s_d;
      rx_n_q    <= rx_n_d;
      rx_sh_q   <= rx_sh_d;
      rx_pen_q  <= rx_pen_d;
      rx_podd_q <= rx_podd_d;
      rx_stp2_q <= rx_stp2_d;
    end
  end

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_s_d    = rx_s_q;
    rx_n_d    = rx_n_q;
    rx_sh_d   = rx_sh_q;
    rx_pen_d  = rx_pen_q;
    rx_podd_d = rx_podd_q;
    rx_stp2_d = rx_stp2_q;
    unique case (rx_st_q)
      ST_IDLE: begin
        if (!rxs) begin
          rx_st_d   = ST_START;
          rx_s_d    = '0;
          rx_pen_d  = bus.par_en_i;
          rx_podd_d = bus.par_odd_i;
          rx_stp2_d = bus.stop2_i;
        end
      end
      ST_START: begin
        // half a bit in: a high line means the edge was a glitch
        if (tick) begin
          if (rx_s_q == CNT_MID) begin
            rx_s_d  = '0;
            rx_n_d  = '0;
            rx_st_d = rxs ? ST_IDLE : ST_DATA;
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) rx_s_d = rx_last ? '0 : rx_s_q + 1'b1;
        if (rx_last) begin
          rx_sh_d = {rxs, rx_sh_q[DBIT-1:1]};
          if (rx_n_q == N_LAST) begin
            rx_n_d  = '0;
            rx_st_d = rx_pen_q ? ST_PAR : ST_STOP;
          end else begin
            rx_n_d = rx_n_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (tick) rx_s_d = rx_last ? '0 : rx_s_q + 1'b1;
        if (rx_last) rx_st_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick) rx_s_d = rx_last ? '0 : rx_s_q + 1'b1;
        if (rx_last) begin
          if (rx_stp2_q && !rx_n_q[0]) rx_n_d = 4'd1;
          else                         rx_st_d = ST_IDLE;
        end
      end
      default: rx_st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_push = 1'b0;
    par_set = 1'b0;
    frm_set = 1'b0;
    unique case (rx_st_q)
      ST_PAR: begin
        par_set = rx_last & (rxs != (^rx_sh_q ^ rx_podd_q));
      end
      ST_STOP: begin
        frm_set = rx_last & ~rxs;
        rx_push = rx_last & (~rx_stp2_q | rx_n_q[0]);
      end
      default: ;
    endcase
  end

  // a simultaneous host pop lets a push into a full FIFO succeed
  assign ovr_set = rx_push & rx_full & ~bus.rd_uart_i;

  // ---------------- sticky errors ----------------
  logic par_q, par_d, frm_q, frm_d, ovr_q, ovr_d;

  assign par_d = par_set | (par_q & ~bus.clr_err_i);
  assign frm_d = frm_set | (frm_q & ~bus.clr_err_i);
  assign ovr_d = ovr_set | (ovr_q & ~bus.clr_err_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      par_q <= 1'b0;
      frm_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      par_q <= par_d;
      frm_q <= frm_d;
      ovr_q <= ovr_d;
    end
  end

  assign bus.tx_o       = tx_q;
  assign bus.tx_full_o  = tx_full;
  assign bus.tx_idle_o  = tx_empty & (tx_st_q == ST_IDLE);
  assign bus.rx_empty_o = rx_empty;
  assign bus.par_err_o  = par_q;
  assign bus.frm_err_o  = frm_q;
  assign bus.ovr_err_o  = ovr_q;
endmodule

// File: tb/tb_uart_cfg.sv
// Self-checking bench for uart_cfg: serial driver/decoder, RX FIFO
// and error-flag model, per-cycle compare plus literal expectations.
module tb_uart_cfg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cfg_if #(.DBIT(8)) u_if ();

  uart_cfg #(.DBIT(8), .FIFO_W(2), .OSR(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_if.slave)
  );

  localparam int BITC = 80;

  logic loop   = 1'b0;
  logic rx_drv = 1'b1;
  assign u_if.rx_i = loop ? u_if.tx_o : rx_drv;

  int n_ass  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  logic [7:0] mq[$];
  bit m_par = 1'b0;
  bit m_frm = 1'b0;
  bit m_ovr = 1'b0;

  int   edq[$];
  logic tx_prev = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    tx_prev <= u_if.tx_o;
    if (u_if.tx_o !== tx_prev) edq.push_back(cyc);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_ass++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 50)
        $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("rx_empty", u_if.rx_empty_o, mq.size() == 0);
      if (mq.size() != 0) chk("r_data", u_if.r_data_o, mq[0]);
      chk("par_err", u_if.par_err_o, m_par);
      chk("frm_err", u_if.frm_err_o, m_frm);
      chk("ovr_err", u_if.ovr_err_o, m_ovr);
    end
  end

  function automatic void m_rx(input logic [7:0] d, input bit pe,
                               input bit podd, input bit pbit,
                               input bit sbit);
    if (pe && (pbit != (^d ^ podd))) m_par = 1'b1;
    if (!sbit) m_frm = 1'b1;
    if (mq.size() < 4) mq.push_back(d);
    else               m_ovr = 1'b1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    @(posedge clk); #1;
    u_if.wr_uart_i = 1'b1;
    u_if.w_data_i  = d;
    @(posedge clk); #1;
    u_if.wr_uart_i = 1'b0;
  endtask

  task automatic rd();
    @(posedge clk); #1;
    u_if.rd_uart_i = 1'b1;
    @(posedge clk); #1;
    u_if.rd_uart_i = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic clr();
    @(posedge clk); #1;
    u_if.clr_err_i = 1'b1;
    @(posedge clk); #1;
    u_if.clr_err_i = 1'b0;
    m_par = 1'b0;
    m_frm = 1'b0;
    m_ovr = 1'b0;
  endtask

  // drives one frame on rx; a bad stop bit is held low only past mid-bit
  task automatic send(input logic [7:0] d, input bit pbit,
                      input bit sbit);
    bit pe, po, two;
    pe  = u_if.par_en_i;
    po  = u_if.par_odd_i;
    two = u_if.stop2_i;
    chk_en = 1'b0;
    rx_drv = 1'b0; tick(BITC);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i]; tick(BITC);
    end
    if (pe) begin
      rx_drv = pbit; tick(BITC);
    end
    if (sbit) begin
      rx_drv = 1'b1; tick(BITC);
    end else begin
      rx_drv = 1'b0; tick(48);
      rx_drv = 1'b1; tick(32);
    end
    if (two) tick(BITC);
    tick(120);
    m_rx(d, pe, po, pbit, sbit);
    chk_en = 1'b1;
  endtask

  task automatic decode(output logic [7:0] d, output logic stp);
    int n;
    n = 0;
    d = '0;
    while (u_if.tx_o !== 1'b0 && n < 5000) begin
      @(negedge clk); n++;
    end
    chk("tx_start_seen", n < 5000, 1);
    repeat (BITC / 2) @(negedge clk);
    chk("tx_start_bit", u_if.tx_o, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (BITC) @(negedge clk);
      d[i] = u_if.tx_o;
    end
    repeat (BITC) @(negedge clk);
    stp = u_if.tx_o;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (u_if.tx_idle_o !== 1'b1 && n < 20000) begin
      @(negedge clk); n++;
    end
    chk("tx_idle_wait", u_if.tx_idle_o, 1);
  endtask

  logic [7:0] d;
  logic       stp;

  initial begin
    u_if.dvsr_i    = 11'd4;
    u_if.par_en_i  = 1'b0;
    u_if.par_odd_i = 1'b0;
    u_if.stop2_i   = 1'b0;
    u_if.wr_uart_i = 1'b0;
    u_if.w_data_i  = '0;
    u_if.rd_uart_i = 1'b0;
    u_if.clr_err_i = 1'b0;

    tick(5);
    chk("rst_tx_o", u_if.tx_o, 1);
    chk("rst_tx_idle", u_if.tx_idle_o, 1);
    chk("rst_tx_full", u_if.tx_full_o, 0);
    chk("rst_rx_empty", u_if.rx_empty_o, 1);
    chk("rst_par", u_if.par_err_o, 0);
    chk("rst_frm", u_if.frm_err_o, 0);
    chk("rst_ovr", u_if.ovr_err_o, 0);
    rst = 1'b0;
    tick(3);
    chk_en = 1'b1;

    // 8N1 transmit of 0xA5 with bit timing
    edq.delete();
    wr(8'hA5);
    decode(d, stp);
    chk("tx_a5_data", d, 8'hA5);
    chk("tx_a5_stop", stp, 1);
    chk("tx_a5_edges", edq.size() >= 8, 1);
    if (edq.size() >= 8) begin
      chk("tx_bit0_len", edq[2] - edq[1], 80);
      chk("tx_bit34_len", edq[5] - edq[4], 160);
      chk("tx_bit6_len", edq[7] - edq[6], 80);
    end
    wait_idle();

    // loopback 8E2
    u_if.par_en_i = 1'b1;
    u_if.stop2_i  = 1'b1;
    chk_en = 1'b0;
    loop   = 1'b1;
    wr(8'h3C);
    wr(8'hFF);
    wait_idle();
    tick(100);
    loop = 1'b0;
    mq.push_back(8'h3C);
    mq.push_back(8'hFF);
    chk_en = 1'b1;
    tick(2);
    chk("lb_first", u_if.r_data_o, 8'h3C);
    rd();
    chk("lb_second", u_if.r_data_o, 8'hFF);
    rd();
    chk("lb_empty", u_if.rx_empty_o, 1);
    chk("lb_par", u_if.par_err_o, 0);
    chk("lb_frm", u_if.frm_err_o, 0);

    // odd-parity frame while even parity is configured
    u_if.stop2_i = 1'b0;
    send(8'h96, 1'b1, 1'b1);
    chk("par_set", u_if.par_err_o, 1);
    chk("par_word", u_if.r_data_o, 8'h96);
    clr();
    chk("par_clr", u_if.par_err_o, 0);
    rd();

    // 8N1 with stop bit low
    u_if.par_en_i = 1'b0;
    send(8'h5A, 1'b0, 1'b0);
    chk("frm_set", u_if.frm_err_o, 1);
    chk("frm_word", u_if.r_data_o, 8'h5A);
    clr();
    rd();

    // 3-tick glitch then a normal frame
    rx_drv = 1'b0; tick(15);
    rx_drv = 1'b1; tick(200);
    chk("glitch_empty", u_if.rx_empty_o, 1);
    send(8'h33, 1'b0, 1'b1);
    chk("after_glitch", u_if.r_data_o, 8'h33);
    rd();

    // overrun: five words, four slots
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 1'b1);
    chk("ovr_set", u_if.ovr_err_o, 1);
    chk("ovr_head", u_if.r_data_o, 8'h01);
    for (int i = 0; i < 3; i++) rd();
    chk("ovr_last", u_if.r_data_o, 8'h04);
    rd();
    chk("ovr_empty", u_if.rx_empty_o, 1);
    clr();

    // fill TX FIFO, then reset mid-data
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      u_if.wr_uart_i = 1'b1;
      u_if.w_data_i  = 8'h10 + 8'(i);
      tick(1);
    end
    u_if.wr_uart_i = 1'b0;
    @(negedge clk);
    chk("tx_full", u_if.tx_full_o, 1);
    wr(8'h99);
    tick(300);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_o", u_if.tx_o, 1);
    chk("mid_rst_idle", u_if.tx_idle_o, 1);
    chk("mid_rst_full", u_if.tx_full_o, 0);
    chk("mid_rst_rx", u_if.rx_empty_o, 1);
    mq.delete();
    m_par = 1'b0;
    m_frm = 1'b0;
    m_ovr = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(3);
    wr(8'hC3);
    decode(d, stp);
    chk("post_rst_data", d, 8'hC3);
    chk("post_rst_stop", stp, 1);
    wait_idle();
    tick(200);
    chk("post_rst_quiet", u_if.tx_idle_o, 1);
    chk("post_rst_line", u_if.tx_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_ass, n_fail);
    $finish;
  end
endmodule
